// File: rtl/pipe_sched_if.sv
// pipe_sched_if: ID-stage decode/hazard inputs and pipeline control outputs of pipe_sched.
interface pipe_sched_if #(parameter int XLEN_REGIDX = 5);
   logic                   dec_valid;
   logic [XLEN_REGIDX-1:0] dec_rs1;
   logic [XLEN_REGIDX-1:0] dec_rs2;
   logic                   dec_use_rs1;
   logic                   dec_use_rs2;
   logic [XLEN_REGIDX-1:0] dec_rd;
   logic                   dec_wr;
   logic                   dec_is_load;
   logic                   br_taken;
   logic                   mem_busy;
   logic                   if_en;
   logic                   id_en;
   logic                   exec_issue;
   logic                   flush;
   logic                   is_fwd_rs1;
   logic                   is_fwd_rs2;
   logic                   fwd_src_rs1;
   logic                   fwd_src_rs2;
   logic [15:0]            stall_cnt;
   modport master (
      output dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_wr, dec_is_load,
             br_taken, mem_busy,
      input  if_en, id_en, exec_issue, flush, is_fwd_rs1, is_fwd_rs2, fwd_src_rs1, fwd_src_rs2,
             stall_cnt
   );
   modport slave (
      input  dec_valid, dec_rs1, dec_rs2, dec_use_rs1, dec_use_rs2, dec_rd, dec_wr, dec_is_load,
             br_taken, mem_busy,
      output if_en, id_en, exec_issue, flush, is_fwd_rs1, is_fwd_rs2, fwd_src_rs1, fwd_src_rs2,
             stall_cnt
   );
endinterface

// File: rtl/pipe_sched.sv
// pipe_sched: 5-stage pipeline sequencer deciding issue/hold/flush of the ID instruction
// and producing registered EX-operand forwarding selects.
module pipe_sched #(
   parameter int FLUSH_CYCLES = 2,
   parameter int XLEN_REGIDX  = 5
) (
   input logic         clk,
   input logic         rst,
   pipe_sched_if.slave bus
);
   typedef enum logic [1:0] {RUN, LU_STALL, FLUSH, MEM_WAIT} state_t;
   state_t                 r_state, r_saved, w_st;
   logic [1:0]             r_fcnt;
   logic [XLEN_REGIDX-1:0] r_ex_rd, r_mem_rd;
   logic                   r_ex_wr, r_ex_ld, r_mem_wr;
   logic                   r_fwd1, r_fwd2, r_src1, r_src2;
   logic [15:0]            r_stall_cnt;
   logic                   w_fl, w_hz, w_run, w_issue;
   logic                   w_e1, w_e2, w_m1, w_m2;
   // Release cycle of a freeze behaves as the state that was interrupted.
   assign w_st  = (r_state == MEM_WAIT) ? r_saved : r_state;
   assign w_fl  = !bus.mem_busy && (bus.br_taken || w_st == FLUSH);
   assign w_hz  = bus.dec_valid && r_ex_ld && r_ex_wr && r_ex_rd != '0 &&
                  ((bus.dec_use_rs1 && bus.dec_rs1 == r_ex_rd) ||
                   (bus.dec_use_rs2 && bus.dec_rs2 == r_ex_rd));
   assign w_run   = !bus.mem_busy && !w_fl && !w_hz;
   assign w_issue = w_run && bus.dec_valid;
   assign w_e1 = bus.dec_use_rs1 && bus.dec_rs1 != '0 && r_ex_wr  && r_ex_rd  == bus.dec_rs1;
   assign w_e2 = bus.dec_use_rs2 && bus.dec_rs2 != '0 && r_ex_wr  && r_ex_rd  == bus.dec_rs2;
   assign w_m1 = bus.dec_use_rs1 && bus.dec_rs1 != '0 && r_mem_wr && r_mem_rd == bus.dec_rs1;
   assign w_m2 = bus.dec_use_rs2 && bus.dec_rs2 != '0 && r_mem_wr && r_mem_rd == bus.dec_rs2;
   assign bus.if_en       = rst && !bus.mem_busy && (w_fl || !w_hz);
   assign bus.id_en       = rst && w_run;
   assign bus.exec_issue  = rst && w_issue;
   assign bus.flush       = rst && w_fl;
   assign bus.is_fwd_rs1  = r_fwd1;
   assign bus.is_fwd_rs2  = r_fwd2;
   assign bus.fwd_src_rs1 = r_src1;
   assign bus.fwd_src_rs2 = r_src2;
   assign bus.stall_cnt   = r_stall_cnt;
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= RUN;
         r_saved     <= RUN;
         r_fcnt      <= '0;
         r_ex_rd     <= '0;
         r_ex_wr     <= 1'b0;
         r_ex_ld     <= 1'b0;
         r_mem_rd    <= '0;
         r_mem_wr    <= 1'b0;
         r_fwd1      <= 1'b0;
         r_fwd2      <= 1'b0;
         r_src1      <= 1'b0;
         r_src2      <= 1'b0;
         r_stall_cnt <= '0;
      end else begin
         if (!w_issue && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
         if (bus.mem_busy) begin
            if (r_state != MEM_WAIT)
               r_saved <= r_state;
            r_state <= MEM_WAIT;
         end else begin
            r_mem_rd <= r_ex_rd;
            r_mem_wr <= r_ex_wr;
            r_ex_rd  <= w_issue ? bus.dec_rd : '0;
            r_ex_wr  <= w_issue && bus.dec_wr;
            r_ex_ld  <= w_issue && bus.dec_is_load;
            r_fwd1   <= w_issue && (w_e1 || w_m1);
            r_fwd2   <= w_issue && (w_e2 || w_m2);
            r_src1   <= w_issue && !w_e1 && w_m1;
            r_src2   <= w_issue && !w_e2 && w_m2;
            if (bus.br_taken) begin
               r_fcnt  <= 2'(FLUSH_CYCLES - 1);
               r_state <= (FLUSH_CYCLES > 1) ? FLUSH : RUN;
            end else if (w_st == FLUSH) begin
               r_fcnt  <= r_fcnt - 2'd1;
               r_state <= (r_fcnt > 2'd1) ? FLUSH : RUN;
            end else begin
               r_state <= w_hz ? LU_STALL : RUN;
            end
         end
      end
   end
endmodule

// File: tb/tb_pipe_sched.sv
// tb_pipe_sched: directed hazard/forwarding/flush/freeze vectors for pipe_sched.
module tb_pipe_sched;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   n_vec = 0;
   int   n_bad = 0;
   pipe_sched_if bus ();
   pipe_sched u_dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic drv(input logic v, input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                      input logic u2, input logic [4:0] rd, input logic wr, input logic ld,
                      input logic br, input logic busy);
      bus.dec_valid = v;   bus.dec_rs1 = rs1; bus.dec_use_rs1 = u1;
      bus.dec_rs2 = rs2;   bus.dec_use_rs2 = u2;
      bus.dec_rd = rd;     bus.dec_wr = wr;   bus.dec_is_load = ld;
      bus.br_taken = br;   bus.mem_busy = busy;
      #4;
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      drv(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
      chk("rst_if_en", 16'(bus.if_en), 0);
      chk("rst_id_en", 16'(bus.id_en), 0);
      chk("rst_issue", 16'(bus.exec_issue), 0);
      chk("rst_flush", 16'(bus.flush), 0);
      chk("rst_fwd1", 16'(bus.is_fwd_rs1), 0);
      chk("rst_cnt", bus.stall_cnt, 0);
      tick();
      rst = 1'b1;
      drv(1, 1, 1, 2, 1, 3, 1, 0, 0, 0);
      chk("a_issue", 16'(bus.exec_issue), 1);
      chk("a_if_en", 16'(bus.if_en), 1);
      chk("a_id_en", 16'(bus.id_en), 1);
      tick();
      drv(1, 3, 1, 3, 1, 4, 1, 0, 0, 0);
      chk("b_issue", 16'(bus.exec_issue), 1);
      chk("b_fwd1_prev", 16'(bus.is_fwd_rs1), 0);
      tick();
      chk("c_fwd1", 16'(bus.is_fwd_rs1), 1);
      chk("c_fwd2", 16'(bus.is_fwd_rs2), 1);
      chk("c_src1", 16'(bus.fwd_src_rs1), 0);
      chk("c_src2", 16'(bus.fwd_src_rs2), 0);
      drv(1, 1, 1, 0, 0, 5, 1, 1, 0, 0);
      chk("c_lw_issue", 16'(bus.exec_issue), 1);
      chk("c_cnt", bus.stall_cnt, 0);
      tick();
      drv(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
      chk("lu_issue", 16'(bus.exec_issue), 0);
      chk("lu_if_en", 16'(bus.if_en), 0);
      chk("lu_id_en", 16'(bus.id_en), 0);
      chk("lu_flush", 16'(bus.flush), 0);
      tick();
      drv(1, 5, 1, 0, 1, 6, 1, 0, 0, 0);
      chk("lu_cnt", bus.stall_cnt, 1);
      chk("lu_bubble_fwd", 16'(bus.is_fwd_rs1), 0);
      chk("lu_reissue", 16'(bus.exec_issue), 1);
      chk("lu_reissue_id", 16'(bus.id_en), 1);
      tick();
      chk("lu_fwd1", 16'(bus.is_fwd_rs1), 1);
      chk("lu_src1", 16'(bus.fwd_src_rs1), 1);
      chk("lu_fwd2_x0", 16'(bus.is_fwd_rs2), 0);
      drv(1, 1, 1, 0, 0, 0, 1, 1, 0, 0);
      chk("x0_lw_issue", 16'(bus.exec_issue), 1);
      tick();
      drv(1, 0, 1, 0, 1, 7, 1, 0, 0, 0);
      chk("x0_no_stall", 16'(bus.exec_issue), 1);
      tick();
      chk("x0_fwd1", 16'(bus.is_fwd_rs1), 0);
      chk("x0_fwd2", 16'(bus.is_fwd_rs2), 0);
      chk("x0_cnt", bus.stall_cnt, 1);
      drv(1, 7, 1, 7, 1, 8, 1, 0, 1, 0);
      chk("br1_flush", 16'(bus.flush), 1);
      chk("br1_issue", 16'(bus.exec_issue), 0);
      chk("br1_if_en", 16'(bus.if_en), 1);
      chk("br1_id_en", 16'(bus.id_en), 0);
      tick();
      drv(1, 7, 1, 7, 1, 8, 1, 0, 1, 0);
      chk("br2_flush", 16'(bus.flush), 1);
      chk("br2_issue", 16'(bus.exec_issue), 0);
      tick();
      drv(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
      chk("br3_flush", 16'(bus.flush), 1);
      chk("br3_issue", 16'(bus.exec_issue), 0);
      chk("br3_if_en", 16'(bus.if_en), 1);
      tick();
      drv(1, 7, 1, 7, 1, 8, 1, 0, 0, 0);
      chk("br_end_flush", 16'(bus.flush), 0);
      chk("br_end_issue", 16'(bus.exec_issue), 1);
      chk("br_cnt", bus.stall_cnt, 4);
      tick();
      drv(1, 1, 1, 2, 1, 9, 1, 0, 1, 0);
      chk("mw_br_flush", 16'(bus.flush), 1);
      tick();
      for (int i = 0; i < 3; i++) begin
         drv(1, 1, 1, 2, 1, 9, 1, 0, 0, 1);
         chk("mw_if_en", 16'(bus.if_en), 0);
         chk("mw_id_en", 16'(bus.id_en), 0);
         chk("mw_issue", 16'(bus.exec_issue), 0);
         tick();
      end
      drv(1, 1, 1, 2, 1, 9, 1, 0, 0, 0);
      chk("mw_rel_flush", 16'(bus.flush), 1);
      chk("mw_rel_issue", 16'(bus.exec_issue), 0);
      chk("mw_rel_if_en", 16'(bus.if_en), 1);
      tick();
      drv(1, 1, 1, 0, 0, 9, 1, 1, 0, 0);
      chk("mw_done_flush", 16'(bus.flush), 0);
      chk("mw_done_issue", 16'(bus.exec_issue), 1);
      chk("mw_cnt", bus.stall_cnt, 9);
      tick();
      drv(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
      chk("rlu_issue", 16'(bus.exec_issue), 0);
      rst = 1'b0;
      #1;
      chk("rlu_if_en", 16'(bus.if_en), 0);
      chk("rlu_issue_rst", 16'(bus.exec_issue), 0);
      chk("rlu_cnt", bus.stall_cnt, 0);
      tick();
      rst = 1'b1;
      drv(1, 9, 1, 0, 0, 10, 1, 0, 0, 0);
      chk("post_issue", 16'(bus.exec_issue), 1);
      chk("post_id_en", 16'(bus.id_en), 1);
      tick();
      chk("post_fwd1", 16'(bus.is_fwd_rs1), 0);
      chk("post_cnt", bus.stall_cnt, 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/pipe_sched.md
Name: pipe_sched

Overview:
- Pipeline sequencer and hazard controller for the 5-stage RV32I core (IF, ID, EX, MEM, WB).
- Each cycle it decides whether the ID-stage instruction is issued into execute, held, or flushed.
- Tracks destination registers of the instructions in EX and MEM and produces registered forwarding selects for the execute operand muxes.
- Generates load-use bubbles, branch/jump flush windows and whole-pipe freezes on data-memory wait.

Parameters:
- FLUSH_CYCLES, 2, cycles of flush after a taken branch/jump (1..3)
- XLEN_REGIDX, 5, register index width

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- dec_valid  in  1  ID holds a valid instruction
- dec_rs1  in  5  ID source register 1
- dec_rs2  in  5  ID source register 2
- dec_use_rs1  in  1  ID instruction reads rs1 as REG operand
- dec_use_rs2  in  1  ID instruction reads rs2 as REG operand
- dec_rd  in  5  ID destination register
- dec_wr  in  1  ID instruction writes rd
- dec_is_load  in  1  ID instruction is a load
- br_taken  in  1  execute reports taken branch/jump (1-cycle pulse)
- mem_busy  in  1  data memory not ready; freeze whole pipe
- if_en  out  1  fetch advances PC / IF register
- id_en  out  1  ID register loads new instruction
- exec_issue  out  1  ID instruction enters EX this edge (drives execute's pipeline-control input)
- flush  out  1  invalidate IF and ID contents
- is_fwd_rs1  out  1  EX operand 1 takes forwarded value
- is_fwd_rs2  out  1  EX operand 2 takes forwarded value
- fwd_src_rs1  out  1  0 = MEM-stage ALU result, 1 = WB value
- fwd_src_rs2  out  1  same for rs2
- stall_cnt  out  16  saturating count of bubble cycles (debug)

Behaviour:
- States: RUN, LU_STALL, FLUSH, MEM_WAIT. Reset → RUN.
- Reset values: if_en=0, id_en=0, exec_issue=0, flush=0, all fwd outputs 0, stall_cnt=0, scoreboard (ex_rd/ex_wr/ex_ld, mem_rd/mem_wr) cleared. First cycle after rst release: RUN, outputs follow the rules below.
- Event priority per cycle: mem_busy > br_taken > load-use > normal issue.
- Load-use hazard (hz): dec_valid & ex_ld & ex_wr & ex_rd!=0 & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
- Output rules per state:
  - RUN, no event: if_en=id_en=1; exec_issue=dec_valid.
  - mem_busy (any state) → MEM_WAIT: if_en=id_en=exec_issue=0; scoreboard and fwd outputs hold. Exit to the saved state when mem_busy=0; a pending flush count resumes where it stopped.
  - br_taken → FLUSH: flush=1 and exec_issue=0 for FLUSH_CYCLES cycles starting the same cycle; if_en=1; id_en=0. A br_taken during FLUSH restarts the count. Return to RUN after the count.
  - hz → LU_STALL: if_en=id_en=exec_issue=0 for exactly 1 cycle; bubble enters EX; then RUN reissues the held instruction.
- Scoreboard, updated at posedge when not frozen:
  - mem_* ← ex_*.
  - ex_* ← dec_* if exec_issue, else cleared (bubble).
- Forwarding, registered at the same edge as exec_issue and computed against pre-update ex_*/mem_*:
  - is_fwd_rsN=1 if the used source matches ex_rd (wr, !=0), with fwd_src=0; else if it matches mem_rd (wr, !=0), with fwd_src=1.
  - ex match wins over mem match.
  - x0 never forwarded.
  - fwd outputs clear to 0 when a bubble is issued.
- stall_cnt increments on every cycle with exec_issue=0 outside reset; saturates at 0xFFFF.
- Reset mid-operation: immediate return to reset values regardless of state or count.

Test Plan:
- Back-to-back `add x3,x1,x2; add x4,x3,x3` → second issue has is_fwd_rs1=is_fwd_rs2=1, fwd_src=0; no stall.
- `lw x5,0(x1); add x6,x5,x0` → one cycle exec_issue=0, if_en=id_en=0, stall_cnt=1; the add then issues with is_fwd_rs1=1, fwd_src_rs1=1.
- Producer to x0 followed by a consumer of x0 → is_fwd=0, no stall even if the producer is a load.
- br_taken pulse → flush=1 and exec_issue=0 for exactly 2 cycles, if_en=1 throughout; second br_taken in flush cycle 2 extends the window to cycle 3.
- mem_busy high for 3 cycles in the middle of a FLUSH window → all enables 0 and flush count frozen; flush completes its remaining cycle after release.
- rst asserted during LU_STALL → outputs immediately zero, stall_cnt=0, scoreboard cleared; after release an instruction dependent on the old load shows no forward and no stall.
